// File: rtl/digit_serial_adder.sv
// WIDTH-bit add/subtract unit that reuses one DIGIT-wide adder slice over WIDTH/DIGIT cycles,
// LSB digit first, with valid/ready handshakes on both sides.
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("digit_serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer/consumer must hold valid and its data until that edge.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] a_d;
    logic [DIGIT-1:0] b_d;
    logic [DIGIT-1:0] s_d;
    logic             c_nxt;
    logic             ovf_d;

    // Operands shift right each RUN edge, so the slice always works on the low digit.
    always_comb begin
        a_d            = a_r[DIGIT-1:0];
        b_d            = b_r[DIGIT-1:0];
        {c_nxt, s_d}   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, c};
        // Equivalent to carry-into-MSB xor carry-out-of-MSB; only used on the MSB digit.
        ovf_d          = (a_d[DIGIT-1] ~^ b_d[DIGIT-1]) & (s_d[DIGIT-1] ^ a_d[DIGIT-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        c     <= sub ? ~ci : ci;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_r <= a_r >> DIGIT;
                    b_r <= b_r >> DIGIT;
                    // New digit enters at the top; after NDIG edges it has reached its slot.
                    sum <= (sum >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));
                    c   <= c_nxt;
                    if (cnt == CW'(NDIG - 1)) begin
                        co    <= c_nxt;
                        ovf   <= ovf_d;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
